vehicle_sensor_if: RTL and testbench
====================================

Name: vehicle_sensor_if

Overview:
Country-road vehicle detector front end that generates the `sensor` input of the highway/country traffic controller and closes the loop on that controller's `country` light output.
- Synchronises and debounces the raw inductive-loop input.
- Counts queued vehicles and drains the queue while the country light is green.
- Holds `sensor` high while any vehicle is waiting or being served.
- Flags starvation when vehicles wait too long without a green.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required before the filtered loop level changes (>=1)
COUNT_W, 4, width of vehicle queue counter; saturates at 2^COUNT_W-1
DEPART_CYCLES, 3, green cycles per departing vehicle
MAX_WAIT, 20, cycles in WAITING before `starved` asserts

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
raw_loop  input  1  asynchronous raw loop detector level, 1 = metal present
country  input  2  country light from controller: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN, 2'b11 treated as RED
sensor  output  1  registered; 1 while queue_count != 0
queue_count  output  COUNT_W  registered vehicles waiting
overflow  output  1  sticky; set when an arrival occurs at full count
starved  output  1  registered; 1 while wait_timer >= MAX_WAIT

Behaviour:
- Reset (synchronous): all outputs 0; sync flops 0; filtered level 0; debounce counter 0; depart timer 0; wait timer 0; state IDLE. Reset asserted mid-operation discards the queue on that edge.
- Sync: raw_loop -> s1 -> s2 (two flops). Only s2 is used downstream.
- Debounce: if s2 == filtered, counter clears. Otherwise counter increments, and on the edge it would reach DEBOUNCE_CYCLES, filtered <= s2 and counter clears. Glitches shorter than DEBOUNCE_CYCLES samples have no effect.
- Arrival: one-cycle pulse when filtered goes 0->1. One vehicle per pulse, regardless of how long it dwells.
- Arrival latency: raw_loop first sampled high at edge 1 -> queue_count and sensor update at edge DEBOUNCE_CYCLES+3 (edge 7 with defaults).
- Departure: depart timer runs only while country==GREEN and queue_count!=0. When it reaches DEPART_CYCLES-1 it produces a departure pulse and reloads to 0. The timer clears whenever country!=GREEN or the queue is empty.
- Count update, same edge:
  - arrival & departure -> unchanged.
  - arrival only -> +1, or hold at max and set overflow.
  - departure only -> -1; never below 0, since departure requires a nonzero count.
- sensor = (next queue_count != 0), registered alongside queue_count. No extra cycle of lag.
- FSM, registered, evaluated on next count/country:
  - IDLE: count==0.
  - WAITING: count>0 & country!=GREEN.
  - SERVING: count>0 & country==GREEN.
  - Transitions:
    - IDLE->WAITING on arrival when not green.
    - IDLE->SERVING on arrival while green.
    - WAITING->SERVING when country becomes GREEN.
    - SERVING->WAITING when country leaves GREEN with vehicles left.
    - SERVING->IDLE when the last vehicle departs.
    - WAITING never returns to IDLE.
- wait_timer:
  - Increments each cycle in WAITING, saturating at MAX_WAIT.
  - Clears in IDLE and SERVING.
  - `starved` asserts on the edge the timer reaches MAX_WAIT and deasserts on the edge the state leaves WAITING.
- YELLOW counts as not green; no departures occur during YELLOW.
- overflow: cleared only by reset.

Test Plan:
1. Reset held 3 cycles with raw_loop=1 -> all outputs 0 throughout. After release, raw_loop high continuously -> queue_count=1 and sensor=1 exactly 7 edges after first sampled high; count stays 1 while the loop stays high.
2. raw_loop pulses high for 2 cycles, country=RED -> no change: queue_count=0, sensor=0.
3. Three clean arrivals (each 8 cycles high, 8 low) with country=RED, then country=GREEN -> queue_count steps 3,2,1,0, one step every 3 cycles. sensor falls on the edge count reaches 0; state returns to IDLE.
4. Single arrival with country=RED held 30 cycles -> starved=1 from 20 cycles after entering WAITING. country=GREEN -> starved=0 next edge; vehicle departs 3 cycles later.
5. Arrival pulse coincident with a departure pulse at count=2 -> count stays 2. country goes YELLOW mid-service -> no departure, state WAITING.
6. COUNT_W=2: five arrivals under RED -> count saturates at 3 and overflow=1. Assert reset mid-sequence -> everything 0 on the next edge, overflow cleared.

Source files
------------

// File: rtl/vehicle_sensor_if.sv
// Country-road vehicle detector front end: sync + debounce loop, count queued
// vehicles, drain the queue on country GREEN, flag starvation while waiting.
// Latency: raw_loop first sampled high at edge 1 -> queue_count/sensor at edge DEBOUNCE_CYCLES+3.
// Ports: clk, reset (sync, active-high), raw_loop (async level), country[1:0] (00 RED,
//        01 YELLOW, 10 GREEN, 11 = RED); sensor, queue_count, overflow (sticky), starved.
module vehicle_sensor_if #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COUNT_W         = 4,
   parameter int DEPART_CYCLES   = 3,
   parameter int MAX_WAIT        = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               raw_loop,
   input  logic [1:0]         country,
   output logic               sensor,
   output logic [COUNT_W-1:0] queue_count,
   output logic               overflow,
   output logic               starved
);

   localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DEP_W  = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DEP_W-1:0]   DEP_LAST = DEP_W'(DEPART_CYCLES - 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_SERVE = 2'd2;

   logic               s1_q, s2_q;
   logic               filt_q, filt_d, filt_prev_q;
   logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic [DEP_W-1:0]   dep_q, dep_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               sensor_q, sensor_d;
   logic               ovf_q, ovf_d;
   logic [1:0]         state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               starved_q, starved_d;

   logic green, arrival, busy, departure;

   always_comb begin
      green   = (country == 2'b10);
      // filt_q rose on the previous edge: exactly one arrival per vehicle
      arrival = filt_q & ~filt_prev_q;

      // Debounce: count consecutive samples that disagree with the filtered level;
      // the edge that would make the run DEBOUNCE_CYCLES long adopts the new level.
      filt_d    = filt_q;
      deb_cnt_d = '0;
      if (s2_q != filt_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            filt_d = s2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
         end
      end

      // Departure timer only runs while serving a non-empty queue on GREEN
      busy      = green && (count_q != '0);
      departure = busy && (dep_q == DEP_LAST);
      dep_d     = (busy && !departure) ? dep_q + DEP_W'(1) : '0;

      count_d = count_q;
      ovf_d   = ovf_q;
      if (arrival && !departure) begin
         if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + COUNT_W'(1);
         end
      end else if (departure && !arrival) begin
         count_d = count_q - COUNT_W'(1);
      end
      sensor_d = (count_d != '0);

      if (count_d == '0) begin
         state_d = ST_IDLE;
      end else if (green) begin
         state_d = ST_SERVE;
      end else begin
         state_d = ST_WAIT;
      end

      // Timer counts cycles spent remaining in WAITING; any exit clears it on that edge
      wait_d = '0;
      if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
         wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
      end
      starved_d = (wait_d == WAIT_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         deb_cnt_q   <= '0;
         dep_q       <= '0;
         count_q     <= '0;
         sensor_q    <= 1'b0;
         ovf_q       <= 1'b0;
         state_q     <= ST_IDLE;
         wait_q      <= '0;
         starved_q   <= 1'b0;
      end else begin
         s1_q        <= raw_loop;
         s2_q        <= s1_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         deb_cnt_q   <= deb_cnt_d;
         dep_q       <= dep_d;
         count_q     <= count_d;
         sensor_q    <= sensor_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         wait_q      <= wait_d;
         starved_q   <= starved_d;
      end
   end

   assign sensor      = sensor_q;
   assign queue_count = count_q;
   assign overflow    = ovf_q;
   assign starved     = starved_q;

endmodule

// File: tb/tb_vehicle_sensor_if.sv
// Bench for vehicle_sensor_if: directed vector table, small-counter saturation
// sequence, and randomized traffic against a behavioural model.
module tb_vehicle_sensor_if;

   localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10;

   logic       clk;
   logic       reset, raw_loop;
   logic [1:0] country;
   logic       sensor, overflow, starved;
   logic [3:0] queue_count;

   logic       reset_b, raw_b;
   logic [1:0] country_b;
   logic       sensor_b, overflow_b, starved_b;
   logic [1:0] qc_b;

   int n_tests = 0;
   int n_fail  = 0;

   vehicle_sensor_if dut (
      .clk(clk), .reset(reset), .raw_loop(raw_loop), .country(country),
      .sensor(sensor), .queue_count(queue_count), .overflow(overflow), .starved(starved)
   );

   vehicle_sensor_if #(.COUNT_W(2)) dut_b (
      .clk(clk), .reset(reset_b), .raw_loop(raw_b), .country(country_b),
      .sensor(sensor_b), .queue_count(qc_b), .overflow(overflow_b), .starved(starved_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model (default parameters) ----------------
   localparam int MD = 4, MDEP = 3, MMAXW = 20, MCMAX = 15;
   bit m_s1, m_s2, m_filt, m_rise, m_wait_state, m_ovf, m_starved;
   bit hist[$];
   int m_cnt, m_run, m_wrun;

   task automatic model_edge(input bit rst, input bit raw, input logic [1:0] c);
      bit green, arr, dep, all_diff;
      int nc;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_filt = 0; m_rise = 0; m_wait_state = 0;
         m_ovf = 0; m_starved = 0; m_cnt = 0; m_run = 0; m_wrun = 0;
         hist.delete();
         return;
      end
      green = (c == G);
      arr   = m_rise;
      // every third consecutive green cycle with vehicles present releases one
      dep   = green && (m_cnt > 0) && (((m_run + 1) % MDEP) == 0);
      m_run = (green && m_cnt > 0) ? m_run + 1 : 0;
      nc = m_cnt + (arr ? 1 : 0) - (dep ? 1 : 0);
      if (nc > MCMAX) begin
         nc = MCMAX;
         m_ovf = 1;
      end
      if (nc > 0 && !green)
         m_wrun = m_wait_state ? ((m_wrun < MMAXW) ? m_wrun + 1 : MMAXW) : 0;
      else
         m_wrun = 0;
      m_wait_state = (nc > 0) && !green;
      m_starved    = (m_wrun >= MMAXW);
      m_cnt        = nc;
      // filtered level flips once the last MD synchronised samples all disagree with it
      hist.push_back(m_s2);
      if (hist.size() > MD) void'(hist.pop_front());
      all_diff = (hist.size() == MD);
      foreach (hist[i]) if (hist[i] == m_filt) all_diff = 0;
      m_rise = all_diff && !m_filt;
      if (all_diff) m_filt = !m_filt;
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   // ---------------- drivers / checkers ----------------
   task automatic tick(input bit rst, input bit raw, input logic [1:0] c);
      reset = rst; raw_loop = raw; country = c;
      model_edge(rst, raw, c);
      @(posedge clk);
      #1;
   endtask

   task automatic tick_b(input bit rst, input bit raw, input logic [1:0] c);
      reset_b = rst; raw_b = raw; country_b = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string name, input int cnt, input bit sens, input bit st, input bit ovf);
      n_tests++;
      if (queue_count !== 4'(cnt) || sensor !== sens || starved !== st || overflow !== ovf) begin
         n_fail++;
         $display("FAIL %s: got cnt=%0d sensor=%b starved=%b ovf=%b, want cnt=%0d sensor=%b starved=%b ovf=%b",
                  name, queue_count, sensor, starved, overflow, cnt, sens, st, ovf);
      end
   endtask

   task automatic check_b(input string name, input int cnt, input bit sens, input bit st, input bit ovf);
      n_tests++;
      if (qc_b !== 2'(cnt) || sensor_b !== sens || starved_b !== st || overflow_b !== ovf) begin
         n_fail++;
         $display("FAIL %s: got cnt=%0d sensor=%b starved=%b ovf=%b, want cnt=%0d sensor=%b starved=%b ovf=%b",
                  name, qc_b, sensor_b, starved_b, overflow_b, cnt, sens, st, ovf);
      end
   endtask

   typedef struct {
      bit         rst;
      bit         raw;
      logic [1:0] ctry;
      int         n;
      int         cnt;
      bit         sens;
      bit         st;
      bit         ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rst, input bit raw, input logic [1:0] c, input int n,
                      input int cnt, input bit sens, input bit st, input bit ovf);
      vec_t v;
      v.rst = rst; v.raw = raw; v.ctry = c; v.n = n;
      v.cnt = cnt; v.sens = sens; v.st = st; v.ovf = ovf;
      tbl.push_back(v);
   endtask

   initial begin
      int raw_hold, c_hold;
      bit r_raw, r_rst;
      logic [1:0] r_c;

      reset = 1; raw_loop = 0; country = R;
      reset_b = 1; raw_b = 0; country_b = R;

      // reset held with loop high, then first arrival lands on edge 7
      add(1,1,R,1, 0,0,0,0); add(1,1,R,1, 0,0,0,0); add(1,1,R,1, 0,0,0,0);
      add(0,1,R,6, 0,0,0,0);
      add(0,1,R,1, 1,1,0,0);
      add(0,1,R,10,1,1,0,0);
      add(0,0,R,8, 1,1,0,0);
      add(0,0,R,1, 1,1,0,0);
      add(0,0,R,1, 1,1,1,0);   // 20 cycles in WAITING
      add(0,0,G,1, 1,1,0,0);   // starved drops on leaving WAITING
      add(0,0,G,1, 1,1,0,0);
      add(0,0,G,1, 0,0,0,0);   // third green cycle departs
      // glitch shorter than debounce window
      add(0,1,R,2, 0,0,0,0);
      add(0,0,R,10,0,0,0,0);
      // three arrivals then drain on GREEN
      add(0,1,R,8, 1,1,0,0); add(0,0,R,8, 1,1,0,0);
      add(0,1,R,8, 2,1,0,0); add(0,0,R,8, 2,1,1,0);
      add(0,1,R,8, 3,1,1,0); add(0,0,R,8, 3,1,1,0);
      add(0,0,G,2, 3,1,0,0);
      add(0,0,G,1, 2,1,0,0);
      add(0,0,G,3, 1,1,0,0);
      add(0,0,G,3, 0,0,0,0);
      // arrival coincident with departure at count 2, then YELLOW
      add(0,1,R,8, 1,1,0,0); add(0,0,R,8, 1,1,0,0);
      add(0,1,R,8, 2,1,0,0); add(0,0,R,8, 2,1,1,0);
      add(0,1,R,4, 2,1,1,0);
      add(0,1,G,2, 2,1,0,0);
      add(0,1,G,1, 2,1,0,0);
      add(0,1,Y,5, 2,1,0,0);
      add(0,1,Y,15,2,1,0,0);
      add(0,1,Y,1, 2,1,1,0);   // YELLOW is WAITING: starves
      add(0,0,G,1, 2,1,0,0);
      add(0,0,G,5, 0,0,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].rst, tbl[i].raw, tbl[i].ctry);
         check_a($sformatf("row%0d", i), tbl[i].cnt, tbl[i].sens, tbl[i].st, tbl[i].ovf);
      end

      // small counter: saturation, sticky overflow, mid-sequence reset
      tick_b(1,0,R);
      check_b("b_reset", 0,0,0,0);
      for (int i = 1; i <= 5; i++) begin
         int e;
         e = 16 * (i - 1);
         for (int k = 0; k < 8; k++) tick_b(0,1,R);
         check_b($sformatf("b_arr%0d_hi", i), (i < 3) ? i : 3, 1, (e + 8) >= 27, i >= 4);
         for (int k = 0; k < 8; k++) tick_b(0,0,R);
         check_b($sformatf("b_arr%0d_lo", i), (i < 3) ? i : 3, 1, (e + 16) >= 27, i >= 4);
      end
      for (int k = 0; k < 3; k++) tick_b(0,1,R);
      check_b("b_pre_reset", 3,1,1,1);
      tick_b(1,1,R);
      check_b("b_mid_reset", 0,0,0,0);
      for (int k = 0; k < 10; k++) tick_b(0,0,R);
      check_b("b_after_reset", 0,0,0,0);

      // randomized traffic against the model
      tick(1,0,R); tick(1,0,R);
      check_a("rand_reset", 0,0,0,0);
      raw_hold = 0; c_hold = 0; r_raw = 0; r_c = R;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (raw_hold == 0) begin
            r_raw = 1'($urandom_range(0, 1));
            raw_hold = $urandom_range(1, 12);
         end
         if (c_hold == 0) begin
            r_c = 2'($urandom_range(0, 3));
            c_hold = $urandom_range(1, 40);
         end
         raw_hold--; c_hold--;
         r_rst = ($urandom_range(0, 999) == 0);
         tick(r_rst, r_raw, r_c);
         check_a($sformatf("rand%0d", cyc), m_cnt, m_cnt != 0, m_starved, m_ovf);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
